// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 16-bit RISC core: captures operands and decoded
// control, inserts load-use bubbles, honours flush/back-pressure and latches halt.
module id_ex_stage #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_src1,
  input  logic [RW-1:0] id_src2,
  input  logic          id_src1_used,
  input  logic          id_src2_used,
  input  logic [RW-1:0] id_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_halt,
  input  logic [3:0]    id_alu_op,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic          flush,
  input  logic          ex_ready,
  output logic          ex_valid,
  output logic [RW-1:0] ex_src1,
  output logic [RW-1:0] ex_src2,
  output logic [RW-1:0] ex_dst,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_halt,
  output logic [3:0]    ex_alu_op,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rdata1,
  output logic [DW-1:0] ex_rdata2,
  output logic          stall_id,
  output logic          halted,
  output logic [CW-1:0] stall_cycles
);

  // state   | meaning
  // RUN     | normal issue into EX
  // HOLD    | EX holds a valid instruction it has not yet accepted
  // HALTED  | HLT accepted by EX; only reset leaves this state
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] src1;
    logic [RW-1:0] src2;
    logic [RW-1:0] dst;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          halt;
    logic [3:0]    alu_op;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
  } ex_t;

  ex_t           ex_q, ex_d, id_pkt;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          lu, hold, halted_st;

  always_comb begin
    halted_st = (state_q == ST_HALTED);
    hold      = ex_q.valid & ~ex_ready;
    lu        = ex_q.valid & ex_q.mem_read & (ex_q.dst != '0) & id_valid &
                ((id_src1_used & (id_src1 == ex_q.dst)) |
                 (id_src2_used & (id_src2 == ex_q.dst)));
    stall_id  = ~flush & (halted_st | lu | hold);

    id_pkt           = '0;
    id_pkt.valid     = id_valid;
    id_pkt.src1      = id_src1;
    id_pkt.src2      = id_src2;
    id_pkt.dst       = id_dst;
    id_pkt.reg_write = id_valid & id_reg_write;
    id_pkt.mem_read  = id_valid & id_mem_read;
    id_pkt.mem_write = id_valid & id_mem_write;
    id_pkt.halt      = id_valid & id_halt;
    id_pkt.alu_op    = id_alu_op;
    id_pkt.imm       = id_imm;
    id_pkt.pc        = id_pc;
    id_pkt.rdata1    = id_rdata1;
    id_pkt.rdata2    = id_rdata2;

    // A bubble clears only control; data fields keep their last value.
    ex_d = ex_q;
    if (flush || halted_st || (!hold && lu)) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
      ex_d.halt      = 1'b0;
    end else if (!hold) begin
      ex_d = id_pkt;
    end

    if (halted_st)                                  state_d = ST_HALTED;
    else if (ex_q.valid && ex_q.halt && ex_ready)   state_d = ST_HALTED;
    else if (hold && !flush)                        state_d = ST_HOLD;
    else                                            state_d = ST_RUN;

    stall_cnt_d = stall_cnt_q;
    if (stall_id && !halted_st && (stall_cnt_q != {CW{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_src1      = ex_q.src1;
  assign ex_src2      = ex_q.src2;
  assign ex_dst       = ex_q.dst;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_halt      = ex_q.halt;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_imm       = ex_q.imm;
  assign ex_pc        = ex_q.pc;
  assign ex_rdata1    = ex_q.rdata1;
  assign ex_rdata2    = ex_q.rdata2;
  assign halted       = halted_st;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage, built with a 4-bit stall counter so the
// saturation point is reachable in a handful of cycles.
module tb_id_ex_stage;
  localparam int DW = 16;
  localparam int RW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_src1_used, id_src2_used;
  logic [RW-1:0] id_src1, id_src2, id_dst;
  logic          id_reg_write, id_mem_read, id_mem_write, id_halt;
  logic [3:0]    id_alu_op;
  logic [DW-1:0] id_imm, id_pc, id_rdata1, id_rdata2;
  logic          flush, ex_ready;
  logic          ex_valid;
  logic [RW-1:0] ex_src1, ex_src2, ex_dst;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_halt;
  logic [3:0]    ex_alu_op;
  logic [DW-1:0] ex_imm, ex_pc, ex_rdata1, ex_rdata2;
  logic          stall_id, halted;
  logic [CW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_halt(id_halt), .id_alu_op(id_alu_op), .id_imm(id_imm), .id_pc(id_pc),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_halt(ex_halt), .ex_alu_op(ex_alu_op), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .stall_id(stall_id),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] s1, input logic u1,
                       input logic [RW-1:0] s2, input logic u2, input logic [RW-1:0] d,
                       input logic rw, input logic mr, input logic mw, input logic h,
                       input logic [3:0] op, input logic [DW-1:0] imm, input logic [DW-1:0] pc,
                       input logic [DW-1:0] r1, input logic [DW-1:0] r2);
    id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
    id_dst = d; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_halt = h;
    id_alu_op = op; id_imm = imm; id_pc = pc; id_rdata1 = r1; id_rdata2 = r2;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    idle();
    flush = 1'b0; ex_ready = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_ex_valid got %0h exp 0", ex_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %0h exp 0", halted); end
    n_cmp++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL rst_stall_id got %0h exp 0", stall_id); end
    @(posedge clk); #1 rst = 1'b1;
    drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 16'h1234, 16'h0002, 16'hAAAA, 16'h5555);
    tick();
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL first_ex_valid got %0h exp 1", ex_valid); end
    n_cmp++; if (ex_rdata1 !== 16'hAAAA) begin n_err++; $display("FAIL first_rdata1 got %0h exp aaaa", ex_rdata1); end
    n_cmp++; if (ex_dst !== 4'd5) begin n_err++; $display("FAIL first_dst got %0h exp 5", ex_dst); end
    ex_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (stall_cycles !== 4'd2) begin n_err++; $display("FAIL pre_rst_stall_cycles got %0d exp 2", stall_cycles); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL midrst_ex_valid got %0h exp 0", ex_valid); end
    n_cmp++; if (ex_rdata1 !== 16'h0) begin n_err++; $display("FAIL midrst_rdata1 got %0h exp 0", ex_rdata1); end
    n_cmp++; if (ex_imm !== 16'h0) begin n_err++; $display("FAIL midrst_imm got %0h exp 0", ex_imm); end
    n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL midrst_stall_cycles got %0d exp 0", stall_cycles); end
    #1 rst = 1'b1;
    ex_ready = 1'b1;
    drive(1'b1, 4'd6, 1'b1, 4'd7, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 16'h0042, 16'h0010, 16'hBEEF, 16'h0000);
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rdata1 !== 16'hBEEF) begin n_err++; $display("FAIL post_rst_load got v=%0h d=%0h exp v=1 d=beef", ex_valid, ex_rdata1); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0004, 16'h0020, 16'h0100, 16'h0000);
    tick();
    drive(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 16'h0000, 16'h0022, 16'h00C3, 16'h0044);
    #1;
    n_cmp++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL lu_stall_id got %0h exp 1", stall_id); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin n_err++; $display("FAIL lu_bubble got v=%0h mr=%0h rw=%0h exp 0 0 0", ex_valid, ex_mem_read, ex_reg_write); end
    n_cmp++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL lu_release got %0h exp 0", stall_id); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rdata1 !== 16'h00C3 || ex_dst !== 4'd5 || ex_alu_op !== 4'h2) begin n_err++; $display("FAIL lu_issue got v=%0h d1=%0h dst=%0h op=%0h exp 1 c3 5 2", ex_valid, ex_rdata1, ex_dst, ex_alu_op); end
    n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL lu_stall_cycles got %0d exp 1", stall_cycles); end
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0024, 16'h0, 16'h0);
    tick();
    drive(1'b1, 4'd2, 1'b1, 4'd7, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 16'h0, 16'h0026, 16'h0, 16'h0);
    #1;
    n_cmp++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL lu_src2_stall got %0h exp 1", stall_id); end
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0030, 16'h0, 16'h0);
    tick();
    drive(1'b1, 4'd0, 1'b1, 4'd2, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0008, 16'h0032, 16'h0000, 16'h0000);
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL r0_stall_id got %0h exp 0", stall_id); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_dst !== 4'd3 || ex_mem_read !== 1'b1) begin n_err++; $display("FAIL r0_issue got v=%0h dst=%0h mr=%0h exp 1 3 1", ex_valid, ex_dst, ex_mem_read); end
    drive(1'b1, 4'd1, 1'b1, 4'd3, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 16'h0, 16'h0034, 16'h0011, 16'h7777);
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL unused_src2_stall got %0h exp 0", stall_id); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rdata2 !== 16'h7777) begin n_err++; $display("FAIL unused_src2_issue got v=%0h d2=%0h exp 1 7777", ex_valid, ex_rdata2); end
    n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL nofalse_stall_cycles got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_backpressure_flush();
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 16'h0BAD, 16'h0040, 16'h1111, 16'h2222);
    tick();
    ex_ready = 1'b0;
    drive(1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 16'h0F00, 16'h0042, 16'h3333, 16'h4444);
    #1;
    n_cmp++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL bp_stall_id got %0h exp 1", stall_id); end
    tick(); tick(); tick();
    n_cmp++; if (ex_imm !== 16'h0BAD || ex_rdata1 !== 16'h1111 || ex_valid !== 1'b1 || ex_mem_write !== 1'b0) begin n_err++; $display("FAIL bp_hold got imm=%0h d1=%0h v=%0h mw=%0h exp bad 1111 1 0", ex_imm, ex_rdata1, ex_valid, ex_mem_write); end
    n_cmp++; if (stall_cycles !== 4'd3) begin n_err++; $display("FAIL bp_stall_cycles got %0d exp 3", stall_cycles); end
    flush = 1'b1;
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_err++; $display("FAIL flush_stall_id got %0h exp 0", stall_id); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_err++; $display("FAIL flush_bubble got v=%0h rw=%0h exp 0 0", ex_valid, ex_reg_write); end
    n_cmp++; if (stall_cycles !== 4'd3) begin n_err++; $display("FAIL flush_stall_cycles got %0d exp 3", stall_cycles); end
    flush = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic test_halt();
    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0, 16'h0050, 16'h0, 16'h0);
    tick();
    ex_ready = 1'b0;
    tick();
    n_cmp++; if (halted !== 1'b0 || ex_halt !== 1'b1) begin n_err++; $display("FAIL halt_pending got h=%0h exh=%0h exp 0 1", halted, ex_halt); end
    ex_ready = 1'b1;
    drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 16'h0, 16'h0052, 16'h0, 16'h0);
    tick();
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set got %0h exp 1", halted); end
    n_cmp++; if (stall_id !== 1'b1) begin n_err++; $display("FAIL halt_stall_id got %0h exp 1", stall_id); end
    n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL halt_cnt_entry got %0d exp 1", stall_cycles); end
    tick(); tick();
    n_cmp++; if (ex_valid !== 1'b0 || halted !== 1'b1) begin n_err++; $display("FAIL halted_bubble got v=%0h h=%0h exp 0 1", ex_valid, halted); end
    n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL halt_cnt_frozen got %0d exp 1", stall_cycles); end
    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0, 16'h0060, 16'h0, 16'h0);
    flush = 1'b1;
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ex_halt !== 1'b0) begin n_err++; $display("FAIL flushed_hlt got v=%0h h=%0h exp 0 0", ex_valid, ex_halt); end
    flush = 1'b0; idle();
    tick(); tick();
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL flushed_hlt_halted got %0h exp 0", halted); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i), 1'b1, 4'(i + 1), 1'b1, 4'(i + 8), 1'b1, 1'b0, 1'b0, 1'b0,
            4'(i + 10), 16'(16'h0100 * i), 16'(16'h0070 + 2 * i), 16'(16'hA000 + i), 16'h0);
      tick();
      n_cmp++; if (ex_valid !== 1'b1 || ex_pc !== 16'(16'h0070 + 2 * i) || ex_alu_op !== 4'(i + 10) || ex_dst !== 4'(i + 8))
        begin n_err++; $display("FAIL b2b_%0d got v=%0h pc=%0h op=%0h dst=%0h", i, ex_valid, ex_pc, ex_alu_op, ex_dst); end
    end
    drive(1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'h9, 16'h5A5A, 16'h0080, 16'h0, 16'h0);
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0 || ex_halt !== 1'b0)
      begin n_err++; $display("FAIL invalid_ctrl got v=%0h rw=%0h mr=%0h mw=%0h h=%0h exp all 0", ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt); end
    n_cmp++; if (ex_imm !== 16'h5A5A) begin n_err++; $display("FAIL invalid_imm got %0h exp 5a5a", ex_imm); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 16'h0, 16'h0090, 16'h0, 16'h0);
    tick();
    ex_ready = 1'b0;
    repeat (14) tick();
    n_cmp++; if (stall_cycles !== 4'd14) begin n_err++; $display("FAIL sat_pre got %0d exp 14", stall_cycles); end
    tick();
    n_cmp++; if (stall_cycles !== 4'd15) begin n_err++; $display("FAIL sat_max got %0d exp 15", stall_cycles); end
    repeat (5) tick();
    n_cmp++; if (stall_cycles !== 4'd15) begin n_err++; $display("FAIL sat_stick got %0d exp 15", stall_cycles); end
    ex_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    idle();
    repeat (2) tick();
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_backpressure_flush();
    test_halt();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
